alu_rs_array: RTL and testbench

ALU_RS_ARRAY -- requirements
Module: alu_rs_array

---
 rtl/rs_pkg.sv | 23 ++
 rtl/rs_slot.sv | 109 ++++++++++
 rtl/alu_rs_array.sv | 167 ++++++++++++++++
 tb/tb_alu_rs_array.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared defaults and the canonical reservation-station entry layout
// for the ALU reservation-station array.
package rs_pkg;

    localparam int RS_WIDTH   = 32;
    localparam int RS_ROB_W   = 3;
    localparam int RS_CTRL_W  = 4;
    localparam int RS_DEPTH   = 4;
    localparam int RS_NUM_CDB = 2;

    typedef struct packed {
        logic                 busy;
        logic [RS_CTRL_W-1:0] ctrl;
        logic [RS_ROB_W-1:0]  rob;
        logic [RS_ROB_W-1:0]  tag1;
        logic [RS_ROB_W-1:0]  tag2;
        logic                 rdy1;
        logic                 rdy2;
        logic [RS_WIDTH-1:0]  val1;
        logic [RS_WIDTH-1:0]  val2;
    } rs_entry_t;

endpackage

// File: rtl/rs_slot.sv
// One reservation-station entry: holds an ALU op, snoops every CDB for its
// pending operands and bypasses a same-cycle broadcast onto its source outputs.
module rs_slot
    import rs_pkg::*;
#(
    parameter int WIDTH   = RS_WIDTH,
    parameter int ROB_W   = RS_ROB_W,
    parameter int CTRL_W  = RS_CTRL_W,
    parameter int NUM_CDB = RS_NUM_CDB
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     alloc_i,
    input  logic                     free_i,
    input  logic [CTRL_W-1:0]        ctrl_i,
    input  logic [ROB_W-1:0]         rob_i,
    input  logic                     rdy1_i,
    input  logic                     rdy2_i,
    input  logic [ROB_W-1:0]         tag1_i,
    input  logic [ROB_W-1:0]         tag2_i,
    input  logic [WIDTH-1:0]         val1_i,
    input  logic [WIDTH-1:0]         val2_i,
    input  logic [NUM_CDB-1:0]       cdb_valid_i,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_i,
    input  logic [NUM_CDB*WIDTH-1:0] cdb_result_i,
    output logic                     busy_o,
    output logic                     eligible_o,
    output logic [CTRL_W-1:0]        ctrl_o,
    output logic [ROB_W-1:0]         rob_o,
    output logic [WIDTH-1:0]         src1_o,
    output logic [WIDTH-1:0]         src2_o
);

    // Same field layout as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic              busy;
        logic [CTRL_W-1:0] ctrl;
        logic [ROB_W-1:0]  rob;
        logic [ROB_W-1:0]  tag1;
        logic [ROB_W-1:0]  tag2;
        logic              rdy1;
        logic              rdy2;
        logic [WIDTH-1:0]  val1;
        logic [WIDTH-1:0]  val2;
    } entry_t;

    entry_t           entry_q;
    logic             hit1, hit2;
    logic [WIDTH-1:0] hit_val1, hit_val2;
    logic             wake1, wake2;

    // Scan high to low so the lowest-index matching bus is the one kept.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        hit_val1 = '0;
        hit_val2 = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (cdb_valid_i[b] && (cdb_rob_i[b*ROB_W +: ROB_W] == entry_q.tag1)) begin
                hit1     = 1'b1;
                hit_val1 = cdb_result_i[b*WIDTH +: WIDTH];
            end
            if (cdb_valid_i[b] && (cdb_rob_i[b*ROB_W +: ROB_W] == entry_q.tag2)) begin
                hit2     = 1'b1;
                hit_val2 = cdb_result_i[b*WIDTH +: WIDTH];
            end
        end
    end

    assign wake1      = entry_q.busy && !entry_q.rdy1 && hit1;
    assign wake2      = entry_q.busy && !entry_q.rdy2 && hit2;
    assign busy_o     = entry_q.busy;
    assign eligible_o = entry_q.busy && (entry_q.rdy1 || hit1) && (entry_q.rdy2 || hit2);
    assign ctrl_o     = entry_q.ctrl;
    assign rob_o      = entry_q.rob;
    assign src1_o     = entry_q.rdy1 ? entry_q.val1 : hit_val1;
    assign src2_o     = entry_q.rdy2 ? entry_q.val2 : hit_val2;

    always_ff @(posedge clk) begin
        if (clear) begin
            entry_q.busy <= 1'b0;
            entry_q.rdy1 <= 1'b0;
            entry_q.rdy2 <= 1'b0;
        end else if (alloc_i) begin
            entry_q.busy <= 1'b1;
            entry_q.ctrl <= ctrl_i;
            entry_q.rob  <= rob_i;
            entry_q.tag1 <= tag1_i;
            entry_q.tag2 <= tag2_i;
            entry_q.rdy1 <= rdy1_i;
            entry_q.rdy2 <= rdy2_i;
            entry_q.val1 <= val1_i;
            entry_q.val2 <= val2_i;
        end else begin
            if (free_i) begin
                entry_q.busy <= 1'b0;
            end
            if (wake1) begin
                entry_q.rdy1 <= 1'b1;
                entry_q.val1 <= hit_val1;
            end
            if (wake2) begin
                entry_q.rdy2 <= 1'b1;
                entry_q.val2 <= hit_val2;
            end
        end
    end

endmodule

// File: rtl/alu_rs_array.sv
// ALU reservation-station array: lowest-free-slot allocation, CDB capture at
// dispatch, and oldest-first issue selection through an age matrix.
module alu_rs_array
    import rs_pkg::*;
#(
    parameter int WIDTH   = RS_WIDTH,
    parameter int ROB_W   = RS_ROB_W,
    parameter int CTRL_W  = RS_CTRL_W,
    parameter int DEPTH   = RS_DEPTH,
    parameter int NUM_CDB = RS_NUM_CDB
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       dispValid,
    output logic                       dispReady,
    input  logic [CTRL_W-1:0]          dispCtrl,
    input  logic [ROB_W-1:0]           dispRob,
    input  logic                       dispRdy1,
    input  logic                       dispRdy2,
    input  logic [WIDTH-1:0]           dispVal1,
    input  logic [WIDTH-1:0]           dispVal2,
    input  logic [ROB_W-1:0]           dispTag1,
    input  logic [ROB_W-1:0]           dispTag2,
    input  logic [NUM_CDB-1:0]         cdbValid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdbRob,
    input  logic [NUM_CDB*WIDTH-1:0]   cdbResult,
    output logic                       issueValid,
    input  logic                       issueReady,
    output logic [CTRL_W-1:0]          issueCtrl,
    output logic [ROB_W-1:0]           issueRob,
    output logic [WIDTH-1:0]           issueSrc1,
    output logic [WIDTH-1:0]           issueSrc2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  age_q [DEPTH];   // age_q[i][j]: entry i dispatched before entry j
    logic [DEPTH-1:0]  slot_busy, slot_elig, sel, alloc_oh, alloc_we;
    logic [CTRL_W-1:0] slot_ctrl [DEPTH];
    logic [ROB_W-1:0]  slot_rob  [DEPTH];
    logic [WIDTH-1:0]  slot_src1 [DEPTH];
    logic [WIDTH-1:0]  slot_src2 [DEPTH];
    logic              disp_fire, issue_fire;
    logic              cap_rdy1, cap_rdy2;
    logic [WIDTH-1:0]  cap_val1, cap_val2;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign dispReady  = !full;
    assign count      = count_q;
    assign disp_fire  = dispValid && dispReady;
    assign issue_fire = issueValid && issueReady;
    assign alloc_we   = alloc_oh & {DEPTH{disp_fire}};

    always_comb begin
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    // A result broadcast in the dispatch cycle would otherwise be missed forever.
    always_comb begin
        cap_rdy1 = dispRdy1;
        cap_rdy2 = dispRdy2;
        cap_val1 = dispVal1;
        cap_val2 = dispVal2;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (!dispRdy1 && cdbValid[b] && (cdbRob[b*ROB_W +: ROB_W] == dispTag1)) begin
                cap_rdy1 = 1'b1;
                cap_val1 = cdbResult[b*WIDTH +: WIDTH];
            end
            if (!dispRdy2 && cdbValid[b] && (cdbRob[b*ROB_W +: ROB_W] == dispTag2)) begin
                cap_rdy2 = 1'b1;
                cap_val2 = cdbResult[b*WIDTH +: WIDTH];
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [DEPTH-1:0] older_elig;

            rs_slot #(
                .WIDTH   (WIDTH),
                .ROB_W   (ROB_W),
                .CTRL_W  (CTRL_W),
                .NUM_CDB (NUM_CDB)
            ) u_slot (
                .clk          (clk),
                .clear        (clear),
                .alloc_i      (alloc_we[gi]),
                .free_i       (sel[gi] && issueReady),
                .ctrl_i       (dispCtrl),
                .rob_i        (dispRob),
                .rdy1_i       (cap_rdy1),
                .rdy2_i       (cap_rdy2),
                .tag1_i       (dispTag1),
                .tag2_i       (dispTag2),
                .val1_i       (cap_val1),
                .val2_i       (cap_val2),
                .cdb_valid_i  (cdbValid),
                .cdb_rob_i    (cdbRob),
                .cdb_result_i (cdbResult),
                .busy_o       (slot_busy[gi]),
                .eligible_o   (slot_elig[gi]),
                .ctrl_o       (slot_ctrl[gi]),
                .rob_o        (slot_rob[gi]),
                .src1_o       (slot_src1[gi]),
                .src2_o       (slot_src2[gi])
            );

            // The diagonal of age_q stays 0, so an entry never blocks itself.
            for (gj = 0; gj < DEPTH; gj++) begin : g_older
                assign older_elig[gj] = slot_elig[gj] && age_q[gj][gi];
            end
            assign sel[gi] = slot_elig[gi] && !(|older_elig);
        end
    endgenerate

    always_comb begin
        issueValid = |sel;
        issueCtrl  = '0;
        issueRob   = '0;
        issueSrc1  = '0;
        issueSrc2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                issueCtrl = slot_ctrl[i];
                issueRob  = slot_rob[i];
                issueSrc1 = slot_src1[i];
                issueSrc2 = slot_src2[i];
            end
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_we[i]) begin
                        age_q[i][j] <= 1'b0;
                    end else if (alloc_we[j]) begin
                        age_q[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_array.sv
// Directed bench for alu_rs_array: dispatch, wakeup, bypass, age order,
// full/back-pressure and clear, with hand-computed expectations.
module tb_alu_rs_array;

    logic        clk = 1'b0;
    logic        clear;
    logic        dispValid, dispReady;
    logic [3:0]  dispCtrl;
    logic [2:0]  dispRob;
    logic        dispRdy1, dispRdy2;
    logic [31:0] dispVal1, dispVal2;
    logic [2:0]  dispTag1, dispTag2;
    logic [1:0]  cdbValid;
    logic [5:0]  cdbRob;
    logic [63:0] cdbResult;
    logic        issueValid, issueReady;
    logic [3:0]  issueCtrl;
    logic [2:0]  issueRob;
    logic [31:0] issueSrc1, issueSrc2;
    logic [2:0]  count;
    logic        full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_rs_array dut (
        .clk        (clk),
        .clear      (clear),
        .dispValid  (dispValid),
        .dispReady  (dispReady),
        .dispCtrl   (dispCtrl),
        .dispRob    (dispRob),
        .dispRdy1   (dispRdy1),
        .dispRdy2   (dispRdy2),
        .dispVal1   (dispVal1),
        .dispVal2   (dispVal2),
        .dispTag1   (dispTag1),
        .dispTag2   (dispTag2),
        .cdbValid   (cdbValid),
        .cdbRob     (cdbRob),
        .cdbResult  (cdbResult),
        .issueValid (issueValid),
        .issueReady (issueReady),
        .issueCtrl  (issueCtrl),
        .issueRob   (issueRob),
        .issueSrc1  (issueSrc1),
        .issueSrc2  (issueSrc2),
        .count      (count),
        .full       (full)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear      = 1'b0;
        dispValid  = 1'b0;
        dispCtrl   = '0;
        dispRob    = '0;
        dispRdy1   = 1'b0;
        dispRdy2   = 1'b0;
        dispVal1   = '0;
        dispVal2   = '0;
        dispTag1   = '0;
        dispTag2   = '0;
        cdbValid   = '0;
        cdbRob     = '0;
        cdbResult  = '0;
        issueReady = 1'b0;
    endtask

    // ctrl is derived from rob so issueCtrl can be checked too
    task automatic disp(input logic [2:0] rob, input logic r1, input logic [31:0] v1,
                        input logic [2:0] t1, input logic [31:0] v2);
        dispValid = 1'b1;
        dispRob   = rob;
        dispCtrl  = {1'b1, rob};
        dispRdy1  = r1;
        dispVal1  = v1;
        dispTag1  = t1;
        dispRdy2  = 1'b1;
        dispVal2  = v2;
        dispTag2  = 3'd0;
    endtask

    task automatic test_reset();
        idle();
        clear = 1'b1;
        cyc();
        cyc();
        clear = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
        checks++; if (dispReady !== 1'b1) begin errors++; $display("FAIL reset_dispReady: got %0b want 1", dispReady); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL reset_issueValid: got %0b want 0", issueValid); end
        checks++; if (issueRob !== 3'd0 || issueCtrl !== 4'd0) begin errors++; $display("FAIL reset_issue_zero: got rob %0d ctrl %0d want 0 0", issueRob, issueCtrl); end
        checks++; if (issueSrc1 !== 32'd0 || issueSrc2 !== 32'd0) begin errors++; $display("FAIL reset_src_zero: got %0h %0h want 0 0", issueSrc1, issueSrc2); end
    endtask

    task automatic test_basic();
        idle();
        disp(3'd2, 1'b1, 32'd5, 3'd0, 32'd7);
        issueReady = 1'b1;
        #1;
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL basic_same_cycle: got %0b want 0", issueValid); end
        cyc();
        dispValid = 1'b0;
        #1;
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", issueValid); end
        checks++; if (issueRob !== 3'd2) begin errors++; $display("FAIL basic_rob: got %0d want 2", issueRob); end
        checks++; if (issueCtrl !== 4'hA) begin errors++; $display("FAIL basic_ctrl: got %0h want a", issueCtrl); end
        checks++; if (issueSrc1 !== 32'd5 || issueSrc2 !== 32'd7) begin errors++; $display("FAIL basic_src: got %0d %0d want 5 7", issueSrc1, issueSrc2); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d want 1", count); end
        cyc();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d want 0", count); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0b want 0", issueValid); end
    endtask

    task automatic test_wakeup_bypass();
        idle();
        disp(3'd3, 1'b0, 32'd0, 3'd1, 32'h10);
        #1;
        cyc();
        dispValid = 1'b0;
        cdbValid  = 2'b01;
        cdbRob    = {3'd0, 3'd4};
        cdbResult = {32'h0, 32'hAA};
        #1;
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL wake_foreign_tag: got %0b want 0", issueValid); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wake_count: got %0d want 1", count); end
        cyc();
        cdbValid   = 2'b10;
        cdbRob     = {3'd1, 3'd0};
        cdbResult  = {32'h55, 32'h0};
        issueReady = 1'b1;
        #1;
        checks++; if (issueValid !== 1'b1) begin errors++; $display("FAIL wake_valid: got %0b want 1", issueValid); end
        checks++; if (issueRob !== 3'd3) begin errors++; $display("FAIL wake_rob: got %0d want 3", issueRob); end
        checks++; if (issueSrc1 !== 32'h55) begin errors++; $display("FAIL wake_bypass: got %0h want 55", issueSrc1); end
        checks++; if (issueSrc2 !== 32'h10) begin errors++; $display("FAIL wake_src2: got %0h want 10", issueSrc2); end
        cyc();
        idle();
        #1;
        checks++; if (count !== 3'd0 || issueValid !== 1'b0) begin errors++; $display("FAIL wake_drained: got count %0d valid %0b want 0 0", count, issueValid); end
    endtask

    task automatic test_cdb_priority();
        idle();
        disp(3'd5, 1'b0, 32'd0, 3'd2, 32'd1);
        #1;
        cyc();
        dispValid = 1'b0;
        cdbValid  = 2'b11;
        cdbRob    = {3'd2, 3'd2};
        cdbResult = {32'h22, 32'h11};
        #1;
        checks++; if (issueSrc1 !== 32'h11) begin errors++; $display("FAIL prio_bypass: got %0h want 11", issueSrc1); end
        cyc();
        cdbValid = 2'b00;
        #1;
        checks++; if (issueValid !== 1'b1 || issueSrc1 !== 32'h11) begin errors++; $display("FAIL prio_captured: got valid %0b src1 %0h want 1 11", issueValid, issueSrc1); end
        issueReady = 1'b1;
        cyc();
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL prio_drained: got %0d want 0", count); end
    endtask

    task automatic test_dispatch_capture();
        idle();
        disp(3'd4, 1'b0, 32'd0, 3'd6, 32'd2);
        cdbValid   = 2'b11;
        cdbRob     = {3'd6, 3'd6};
        cdbResult  = {32'h99, 32'd9};
        issueReady = 1'b1;
        #1;
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL cap_same_cycle: got %0b want 0", issueValid); end
        cyc();
        dispValid = 1'b0;
        cdbValid  = 2'b00;
        #1;
        checks++; if (issueValid !== 1'b1 || issueRob !== 3'd4) begin errors++; $display("FAIL cap_issue: got valid %0b rob %0d want 1 4", issueValid, issueRob); end
        checks++; if (issueSrc1 !== 32'd9 || issueSrc2 !== 32'd2) begin errors++; $display("FAIL cap_src: got %0h %0h want 9 2", issueSrc1, issueSrc2); end
        cyc();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL cap_drained: got %0d want 0", count); end
    endtask

    task automatic test_full_order();
        int exp_rob [4] = '{1, 2, 3, 5};
        idle();
        for (int k = 0; k < 4; k++) begin
            disp(3'(k), 1'b1, 32'(k * 16), 3'd0, 32'd0);
            #1;
            cyc();
        end
        disp(3'd7, 1'b1, 32'd70, 3'd0, 32'd0);
        issueReady = 1'b1;
        #1;
        checks++; if (full !== 1'b1 || dispReady !== 1'b0) begin errors++; $display("FAIL full_flags: got full %0b dispReady %0b want 1 0", full, dispReady); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count4: got %0d want 4", count); end
        checks++; if (issueRob !== 3'd0) begin errors++; $display("FAIL full_first_rob: got %0d want 0", issueRob); end
        cyc();
        disp(3'd5, 1'b1, 32'd80, 3'd0, 32'd0);
        issueReady = 1'b0;
        #1;
        checks++; if (count !== 3'd3 || dispReady !== 1'b1) begin errors++; $display("FAIL full_refused: got count %0d dispReady %0b want 3 1", count, dispReady); end
        cyc();
        dispValid  = 1'b0;
        issueReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (issueValid !== 1'b1 || issueRob !== 3'(exp_rob[i])) begin errors++; $display("FAIL full_order_%0d: got valid %0b rob %0d want 1 %0d", i, issueValid, issueRob, exp_rob[i]); end
            cyc();
        end
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", count); end
    endtask

    task automatic test_age();
        idle();
        disp(3'd1, 1'b0, 32'd0, 3'd3, 32'd0);
        #1;
        cyc();
        disp(3'd2, 1'b1, 32'd2, 3'd0, 32'd0);
        #1;
        cyc();
        dispValid = 1'b0;
        #1;
        checks++; if (issueRob !== 3'd2) begin errors++; $display("FAIL age_only_b: got %0d want 2", issueRob); end
        cdbValid   = 2'b01;
        cdbRob     = {3'd0, 3'd3};
        cdbResult  = {32'h0, 32'h33};
        issueReady = 1'b1;
        #1;
        checks++; if (issueRob !== 3'd1 || issueSrc1 !== 32'h33) begin errors++; $display("FAIL age_a_first: got rob %0d src1 %0h want 1 33", issueRob, issueSrc1); end
        cyc();
        cdbValid = 2'b00;
        #1;
        checks++; if (issueRob !== 3'd2 || issueValid !== 1'b1) begin errors++; $display("FAIL age_b_second: got rob %0d valid %0b want 2 1", issueRob, issueValid); end
        cyc();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL age_drained: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        idle();
        issueReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            disp(3'(k), 1'b1, 32'(k), 3'd0, 32'd0);
            #1;
            if (k > 0) begin
                checks++; if (issueValid !== 1'b1 || issueRob !== 3'(k - 1)) begin errors++; $display("FAIL b2b_rob_%0d: got valid %0b rob %0d want 1 %0d", k, issueValid, issueRob, k - 1); end
                checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count_%0d: got %0d want 1", k, count); end
            end
            cyc();
        end
        dispValid = 1'b0;
        #1;
        checks++; if (issueRob !== 3'd3 || count !== 3'd1) begin errors++; $display("FAIL b2b_last: got rob %0d count %0d want 3 1", issueRob, count); end
        cyc();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", count); end
    endtask

    task automatic test_clear();
        idle();
        for (int k = 0; k < 3; k++) begin
            disp(3'(k), 1'b0, 32'd0, 3'd7, 32'd0);
            #1;
            cyc();
        end
        clear = 1'b1;
        disp(3'd3, 1'b1, 32'd1, 3'd0, 32'd1);
        cdbValid   = 2'b01;
        cdbRob     = {3'd0, 3'd7};
        cdbResult  = {32'h0, 32'h77};
        issueReady = 1'b1;
        #1;
        cyc();
        idle();
        #1;
        checks++; if (count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL clear_count: got count %0d full %0b want 0 0", count, full); end
        checks++; if (issueValid !== 1'b0) begin errors++; $display("FAIL clear_issueValid: got %0b want 0", issueValid); end
        checks++; if (dispReady !== 1'b1) begin errors++; $display("FAIL clear_dispReady: got %0b want 1", dispReady); end
        cyc();
        #1;
        checks++; if (issueValid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL clear_settled: got valid %0b count %0d want 0 0", issueValid, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup_bypass();
        test_cdb_priority();
        test_dispatch_capture();
        test_full_order();
        test_age();
        test_back_to_back();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
